// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS program controller: command bytes, state
// encoding and the fixed word widths of the fetch stage.
package mips_ctrl_pkg;
  localparam int PC_LENGTH          = 32;
  localparam int INSTRUCTION_LENGTH = 32;

  localparam logic [INSTRUCTION_LENGTH-1:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP  = 8'h53;  // 'S'
  localparam logic [7:0] CMD_RERUN = 8'h58;  // 'X'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PCCLR,
    ST_READY,
    ST_RUN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/mips_program_controller_if.sv
// Bundle between the controller, the UART receiver and the fetch stage.
// master = controller side, slave = UART/pipeline/imem side.
interface mips_program_controller_if;
  import mips_ctrl_pkg::*;

  logic [7:0]                    rx_data;
  logic                          rx_valid;
  logic                          halt_detected;
  logic                          instr_wr_en;
  logic [PC_LENGTH-1:0]          instr_wr_addr;
  logic [INSTRUCTION_LENGTH-1:0] instr_wr_data;
  logic                          start;
  logic                          mips_enable;
  logic                          mips_reset;
  logic                          done;
  logic [31:0]                   cycle_count;

  modport master (
    input  rx_data, rx_valid, halt_detected,
    output instr_wr_en, instr_wr_addr, instr_wr_data,
    output start, mips_enable, mips_reset, done, cycle_count
  );

  modport slave (
    output rx_data, rx_valid, halt_detected,
    input  instr_wr_en, instr_wr_addr, instr_wr_data,
    input  start, mips_enable, mips_reset, done, cycle_count
  );
endinterface

// File: rtl/mips_program_controller_word_assembler.sv
// Packs four bytes MSB-first into one instruction word. word/word_valid are
// combinational on the 4th byte so the caller can register the write itself.
module word_assembler
  import mips_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic [INSTRUCTION_LENGTH-1:0] word,
  output logic                          word_valid
);
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = cnt_q + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign word       = {shift_q, byte_in};
  assign word_valid = byte_valid && !clear && (cnt_q == 2'd3);
endmodule

// File: rtl/mips_program_controller.sv
// Loads a program from the UART byte stream into instruction memory, then
// runs or single-steps the fetch stage until the pipeline reports a halt.
module mips_program_controller #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] HALT_WORD  = mips_ctrl_pkg::HALT_WORD
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_program_controller_if.master bus
);
  import mips_ctrl_pkg::*;

  localparam int PTR_W = $clog2(IMEM_WORDS) + 1;

  state_t                        state_q, state_d;
  logic [PTR_W-1:0]              ptr_q, ptr_d;
  logic                          wr_en_q, wr_en_d;
  logic [PC_LENGTH-1:0]          addr_q, addr_d;
  logic [INSTRUCTION_LENGTH-1:0] data_q, data_d;
  logic                          start_q, start_d;
  logic                          en_q, en_d;
  logic                          mrst_q, mrst_d;
  logic                          done_q, done_d;
  logic [31:0]                   count_q, count_d;
  logic                          step;

  logic [INSTRUCTION_LENGTH-1:0] word;
  logic                          word_valid;

  // Held clear outside LOAD so every load starts on a word boundary.
  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q != ST_LOAD),
    .byte_in   (bus.rx_data),
    .byte_valid(bus.rx_valid),
    .word      (word),
    .word_valid(word_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    step    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.rx_valid && bus.rx_data == CMD_LOAD) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_LOAD: begin
        if (word_valid) begin
          wr_en_d = 1'b1;
          addr_d  = PC_LENGTH'({ptr_q, 2'b00});
          data_d  = word;
          ptr_d   = ptr_q + PTR_W'(1);
          if (word == HALT_WORD || ptr_q == PTR_W'(IMEM_WORDS - 1))
            state_d = ST_PCCLR;
        end
      end
      ST_PCCLR: state_d = ST_READY;
      ST_READY: begin
        // A halt beats any byte arriving in the same cycle.
        if (bus.halt_detected) begin
          state_d = ST_DONE;
        end else if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: step    = 1'b1;
            CMD_LOAD: begin
              state_d = ST_LOAD;
              ptr_d   = '0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (bus.halt_detected) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            CMD_RERUN: state_d = ST_PCCLR;
            CMD_LOAD: begin
              state_d = ST_LOAD;
              ptr_d   = '0;
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Control outputs are registered copies of what the next state implies.
    start_d = !(state_d inside {ST_IDLE, ST_LOAD});
    mrst_d  = state_d inside {ST_IDLE, ST_LOAD, ST_PCCLR};
    done_d  = (state_d == ST_DONE);
    en_d    = (state_d == ST_RUN) || (state_d == ST_PCCLR) || step;

    if (state_d == ST_PCCLR)     count_d = '0;
    else if (en_d && !mrst_d)    count_d = count_q + 32'd1;
    else                         count_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      mrst_q  <= 1'b1;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      en_q    <= en_d;
      mrst_q  <= mrst_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign bus.instr_wr_en   = wr_en_q;
  assign bus.instr_wr_addr = addr_q;
  assign bus.instr_wr_data = data_q;
  assign bus.start         = start_q;
  assign bus.mips_enable   = en_q;
  assign bus.mips_reset    = mrst_q;
  assign bus.done          = done_q;
  assign bus.cycle_count   = count_q;
endmodule

// File: tb/tb_mips_program_controller.sv
// Directed bench for the program controller: a vector table for load/step,
// then hand-written run/halt, rerun, full-memory and mid-load reset sequences.
module tb_mips_program_controller;
  localparam logic [7:0] B_L = 8'h4C, B_R = 8'h52, B_S = 8'h53, B_X = 8'h58;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   en_hi;

  mips_program_controller_if bus ();

  mips_program_controller #(.IMEM_WORDS(4), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rxv;
    logic [7:0]  rxd;
    logic        halt;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        st;
    logic        en;
    logic        mr;
    logic        dn;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rxv, logic [7:0] rxd, logic halt, logic wr,
                              logic [31:0] addr, logic [31:0] data, logic st,
                              logic en, logic mr, logic dn, logic [31:0] cnt);
    vec_t v;
    v.rxv = rxv; v.rxd = rxd; v.halt = halt; v.wr = wr; v.addr = addr;
    v.data = data; v.st = st; v.en = en; v.mr = mr; v.dn = dn; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare outputs just after the edge.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    bus.rx_valid      = v.rxv;
    bus.rx_data       = v.rxd;
    bus.halt_detected = v.halt;
    @(posedge clk);
    #1;
    if (bus.mips_enable === 1'b1) en_hi++;
    check({tag, ".wr_en"},  32'(bus.instr_wr_en), 32'(v.wr));
    if (v.wr) begin
      check({tag, ".addr"}, bus.instr_wr_addr, v.addr);
      check({tag, ".data"}, bus.instr_wr_data, v.data);
    end
    check({tag, ".start"},  32'(bus.start),       32'(v.st));
    check({tag, ".enable"}, 32'(bus.mips_enable), 32'(v.en));
    check({tag, ".mreset"}, 32'(bus.mips_reset),  32'(v.mr));
    check({tag, ".done"},   32'(bus.done),        32'(v.dn));
    check({tag, ".count"},  bus.cycle_count,      v.cnt);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".wr_en"},  32'(bus.instr_wr_en), 32'd0);
    check({tag, ".addr"},   bus.instr_wr_addr,    32'd0);
    check({tag, ".data"},   bus.instr_wr_data,    32'd0);
    check({tag, ".start"},  32'(bus.start),       32'd0);
    check({tag, ".enable"}, 32'(bus.mips_enable), 32'd0);
    check({tag, ".mreset"}, 32'(bus.mips_reset),  32'd1);
    check({tag, ".done"},   32'(bus.done),        32'd0);
    check({tag, ".count"},  bus.cycle_count,      32'd0);
  endtask

  // 'R' then halt on the 11th enabled cycle; byte arriving with the halt is dropped.
  task automatic run_and_halt(input logic [31:0] base, input string tag);
    en_hi = 0;
    apply(mk(1, B_R, 0, 0, 0, 0, 1, 1, 0, 0, base + 32'd1), {tag, ".go"});
    for (int i = 1; i <= 10; i++)
      apply(mk(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 0, base + 32'd1 + 32'(i)),
            $sformatf("%s.run%0d", tag, i));
    apply(mk(1, B_S, 1, 0, 0, 0, 1, 0, 0, 1, base + 32'd11), {tag, ".halt"});
    check({tag, ".en_cycles"}, 32'(en_hi), 32'd11);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    en_hi  = 0;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = 8'h00;
    bus.halt_detected = 1'b0;
    reset             = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b0;

    // IDLE ignores non-'L', then load 3 words ending in the halt word, then steps.
    tbl.push_back(mk(1, B_R,   0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, B_L,   0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 1, 0, 32'h1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 1, 4, 32'h2, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 0, 1, 8, 32'hFFFF_FFFF, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, B_S,   0, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, B_S,   0, 0, 0, 0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h41, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, B_S,   0, 0, 0, 0, 1, 1, 0, 0, 3));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 3));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Run from READY with count 3 carried over from the steps.
    run_and_halt(32'd3, "run1");
    apply(mk(1, B_R, 0, 0, 0, 0, 1, 0, 0, 1, 14), "done.ign_r");
    apply(mk(1, B_S, 0, 0, 0, 0, 1, 0, 0, 1, 14), "done.ign_s");

    // Rerun: PCCLR pulse clears count and done, then a fresh run.
    apply(mk(1, B_X,   0, 0, 0, 0, 1, 1, 1, 0, 0), "rerun.pcclr");
    apply(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0), "rerun.ready");
    run_and_halt(32'd0, "run2");

    // Halt in READY wins over a simultaneous 'R'.
    apply(mk(1, B_X,   0, 0, 0, 0, 1, 1, 1, 0, 0), "hw.pcclr");
    apply(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0), "hw.ready");
    apply(mk(1, B_R,   1, 0, 0, 0, 1, 0, 0, 1, 0), "hw.halt");

    // Full memory: four non-halt words fill IMEM_WORDS=4, extra bytes ignored.
    apply(mk(1, B_L, 0, 0, 0, 0, 0, 0, 1, 0, 0), "full.L");
    for (int w = 0; w < 4; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (b < 3)
          apply(mk(1, 8'h10 + 8'(w), 0, 0, 0, 0, 0, 0, 1, 0, 0),
                $sformatf("full.w%0db%0d", w, b));
        else if (w < 3)
          apply(mk(1, 8'h10 + 8'(w), 0, 1, 32'(w * 4), {4{8'h10 + 8'(w)}}, 0, 0, 1, 0, 0),
                $sformatf("full.w%0dwr", w));
        else
          apply(mk(1, 8'h13, 0, 1, 32'd12, 32'h1313_1313, 1, 1, 1, 0, 0), "full.last");
      end
    end
    for (int b = 0; b < 4; b++)
      apply(mk(1, 8'hAA, 0, 0, 0, 0, 1, 0, 0, 0, 0), $sformatf("full.extra%0d", b));

    // Reset after two bytes of a word: partial word discarded, reload at addr 0.
    apply(mk(1, B_L,   0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.L");
    apply(mk(1, 8'hDE, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.b0");
    apply(mk(1, 8'hAD, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.b1");
    @(negedge clk);
    reset        = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hBE;
    @(posedge clk);
    #1;
    check_reset_vals("rl.rst");
    @(negedge clk);
    reset = 1'b0;
    apply(mk(1, 8'hEF, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.idle_ef");
    apply(mk(1, B_L,   0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.L2");
    apply(mk(1, 8'hDE, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.c0");
    apply(mk(1, 8'hAD, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.c1");
    apply(mk(1, 8'hBE, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.c2");
    apply(mk(1, 8'hEF, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 0), "rl.c3");
    apply(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0), "rl.after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
